// File: rtl/matop_pkg.sv
// Shared types and constants for the matrix-op arbiter: FSM state encoding,
// matrix dimension limits and the operand dimension check.
package matop_pkg;

   localparam int MAT_DIM   = 5;
   localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      LAUNCH  = 3'd2,
      SETTLE  = 3'd3,
      CAPTURE = 3'd4,
      DONE    = 3'd5
   } state_e;

   function automatic logic dim_valid(input logic [2:0] d);
      return (d >= 3'd1) && (d <= 3'(MAT_DIM));
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that was not served last
// wins. Purely combinational; the caller owns the last-served register.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o,
   output logic       idx_o
);

   always_comb begin
      idx_o = 1'b0;
      if (req_i == 2'b11) begin
         idx_o = ~last_i;
      end else if (req_i[1]) begin
         idx_o = 1'b1;
      end
      gnt_o = 2'b00;
      if (|req_i) begin
         gnt_o = idx_o ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/matrix_op_arbiter.sv
// Arbitrates two requesters onto one shared matrix op unit and registers its
// result. Define MATOP_TIMEOUT_EN to build the unit_busy watchdog in SETTLE.
module matrix_op_arbiter
   import matop_pkg::*;
#(
   parameter int DATA_WIDTH     = 9,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [1:0]                          req,
   input  logic [5:0]                          req_r,
   input  logic [5:0]                          req_c,
   input  logic [2*MAT_ELEMS*DATA_WIDTH-1:0]   req_data,
   output logic [1:0]                          gnt,
   output logic [1:0]                          done,
   output logic                                err,
   output logic [2:0]                          res_r,
   output logic [2:0]                          res_c,
   output logic [MAT_ELEMS*DATA_WIDTH-1:0]     res_data,
   output logic                                unit_en,
   output logic [2:0]                          unit_r,
   output logic [2:0]                          unit_c,
   output logic [MAT_ELEMS*DATA_WIDTH-1:0]     unit_data,
   input  logic                                unit_busy,
   input  logic [2:0]                          unit_r_out,
   input  logic [2:0]                          unit_c_out,
   input  logic [MAT_ELEMS*DATA_WIDTH-1:0]     unit_data_out
);

   localparam int         MW          = MAT_ELEMS * DATA_WIDTH;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES out of range 1..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..255");
   end

   state_e          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic            win_q, win_d;
   logic            last_q, last_d;
   logic            err_q, err_d;
   logic [2:0]      op_r_q, op_r_d;
   logic [2:0]      op_c_q, op_c_d;
   logic [MW-1:0]   op_data_q, op_data_d;
   logic [2:0]      res_r_q, res_r_d;
   logic [2:0]      res_c_q, res_c_d;
   logic [MW-1:0]   res_data_q, res_data_d;
   logic [3:0]      settle_q, settle_d;

   logic [1:0]      arb_gnt;
   logic            arb_idx;
   logic            req_win;
   logic            settle_met;

`ifdef MATOP_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]      to_q, to_d;
`endif

   rr_arbiter2 u_arb (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx)
   );

   assign req_win    = req[win_q];
   assign settle_met = (settle_q == SETTLE_LAST);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      win_d      = win_q;
      last_d     = last_q;
      err_d      = err_q;
      op_r_d     = op_r_q;
      op_c_d     = op_c_q;
      op_data_d  = op_data_q;
      res_r_d    = res_r_q;
      res_c_d    = res_c_q;
      res_data_d = res_data_q;
      settle_d   = settle_q;
`ifdef MATOP_TIMEOUT_EN
      to_d       = to_q;
`endif

      // Losing req[winner] anywhere before DONE abandons the operation quietly.
      if (state_q != IDLE && state_q != DONE && !req_win) begin
         state_d = IDLE;
         gnt_d   = 2'b00;
         last_d  = win_q;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_d   = CHECK;
                  gnt_d     = arb_gnt;
                  win_d     = arb_idx;
                  err_d     = 1'b0;
                  op_r_d    = arb_idx ? req_r[5:3] : req_r[2:0];
                  op_c_d    = arb_idx ? req_c[5:3] : req_c[2:0];
                  op_data_d = arb_idx ? req_data[2*MW-1:MW] : req_data[MW-1:0];
               end
            end
            CHECK: begin
               if (!dim_valid(op_r_q) || !dim_valid(op_c_q)) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = LAUNCH;
               end
            end
            LAUNCH: begin
               state_d  = SETTLE;
               settle_d = 4'd0;
`ifdef MATOP_TIMEOUT_EN
               to_d     = 8'd0;
`endif
            end
            SETTLE: begin
               if (!settle_met) begin
                  settle_d = settle_q + 4'd1;
               end else if (!unit_busy) begin
                  state_d = CAPTURE;
               end
`ifdef MATOP_TIMEOUT_EN
               else if (to_q == TO_LAST) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  to_d = to_q + 8'd1;
               end
`endif
            end
            CAPTURE: begin
               state_d    = DONE;
               err_d      = 1'b0;
               res_r_d    = unit_r_out;
               res_c_d    = unit_c_out;
               res_data_d = unit_data_out;
            end
            DONE: begin
               if (!req_win) begin
                  state_d = IDLE;
                  gnt_d   = 2'b00;
                  last_d  = win_q;
               end
            end
            default: begin
               state_d = IDLE;
               gnt_d   = 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= 2'b00;
         win_q      <= 1'b0;
         last_q     <= 1'b1;
         err_q      <= 1'b0;
         op_r_q     <= '0;
         op_c_q     <= '0;
         op_data_q  <= '0;
         res_r_q    <= '0;
         res_c_q    <= '0;
         res_data_q <= '0;
         settle_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         win_q      <= win_d;
         last_q     <= last_d;
         err_q      <= err_d;
         op_r_q     <= op_r_d;
         op_c_q     <= op_c_d;
         op_data_q  <= op_data_d;
         res_r_q    <= res_r_d;
         res_c_q    <= res_c_d;
         res_data_q <= res_data_d;
         settle_q   <= settle_d;
      end
   end

`ifdef MATOP_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`endif

   // Operands are only reloaded in IDLE, so they stay stable across LAUNCH..CAPTURE.
   assign unit_en   = (state_q == LAUNCH) || (state_q == SETTLE) || (state_q == CAPTURE);
   assign unit_r    = op_r_q;
   assign unit_c    = op_c_q;
   assign unit_data = op_data_q;
   assign gnt       = gnt_q;
   assign done      = (state_q == DONE) ? gnt_q : 2'b00;
   assign err       = (state_q == DONE) && err_q;
   assign res_r     = res_r_q;
   assign res_c     = res_c_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_matrix_op_arbiter.sv
// Directed bench for matrix_op_arbiter; cycle k means "#1 after the k-th edge
// following the cycle in which IDLE samples req".
module tb_matrix_op_arbiter;

   localparam int W  = 9;
   localparam int MW = 25 * W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [1:0]        req;
   logic [5:0]        req_r, req_c;
   logic [2*MW-1:0]   req_data;
   logic [1:0]        gnt, done;
   logic              err;
   logic [2:0]        res_r, res_c;
   logic [MW-1:0]     res_data;
   logic              unit_en;
   logic [2:0]        unit_r, unit_c;
   logic [MW-1:0]     unit_data;
   logic              unit_busy;
   logic [2:0]        unit_r_out, unit_c_out;
   logic [MW-1:0]     unit_data_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2:0]    exp_res_r;
   logic [2:0]    exp_res_c;
   logic [MW-1:0] exp_res_data;

   matrix_op_arbiter #(
      .DATA_WIDTH     (W),
      .SETTLE_CYCLES  (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .req_r         (req_r),
      .req_c         (req_c),
      .req_data      (req_data),
      .gnt           (gnt),
      .done          (done),
      .err           (err),
      .res_r         (res_r),
      .res_c         (res_c),
      .res_data      (res_data),
      .unit_en       (unit_en),
      .unit_r        (unit_r),
      .unit_c        (unit_c),
      .unit_data     (unit_data),
      .unit_busy     (unit_busy),
      .unit_r_out    (unit_r_out),
      .unit_c_out    (unit_c_out),
      .unit_data_out (unit_data_out)
   );

   function automatic logic [MW-1:0] pat(input int seed);
      logic [MW-1:0] v;
      for (int k = 0; k < 25; k++) v[k*W +: W] = 9'((seed * 31 + k * 7) & 511);
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; req = 2'b00; req_r = '0; req_c = '0; req_data = '0;
      unit_busy = 1'b0; unit_r_out = '0; unit_c_out = '0; unit_data_out = '0;
      exp_res_r = '0; exp_res_c = '0; exp_res_data = '0;
      tick; tick;
      reset = 1'b0;
      tick;
      n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL reset_done: got %b want 00", done); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if (unit_en !== 1'b0) begin n_bad++; $display("FAIL reset_unit_en: got %b want 0", unit_en); end
      n_cmp++; if (unit_r !== 3'd0 || unit_c !== 3'd0 || unit_data !== '0) begin
         n_bad++; $display("FAIL reset_unit_ops: got r=%0d c=%0d data=%h want zeros", unit_r, unit_c, unit_data);
      end
      n_cmp++; if (res_r !== 3'd0 || res_c !== 3'd0 || res_data !== '0) begin
         n_bad++; $display("FAIL reset_res: got r=%0d c=%0d data=%h want zeros", res_r, res_c, res_data);
      end
   endtask

   task automatic test_basic;
      req_r = {3'd1, 3'd3}; req_c = {3'd1, 3'd3}; req_data = {pat(9), pat(1)};
      unit_r_out = 3'd3; unit_c_out = 3'd3; unit_data_out = pat(2); unit_busy = 1'b0;
      req = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         tick;
         n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL basic_gnt k=%0d: got %b want 01", k, gnt); end
         n_cmp++; if (unit_en !== (k >= 2 && k <= 5)) begin
            n_bad++; $display("FAIL basic_unit_en k=%0d: got %b want %b", k, unit_en, (k >= 2 && k <= 5));
         end
         n_cmp++; if (done !== ((k == 6) ? 2'b01 : 2'b00)) begin
            n_bad++; $display("FAIL basic_done k=%0d: got %b want %b", k, done, ((k == 6) ? 2'b01 : 2'b00));
         end
         if (k >= 2 && k <= 5) begin
            n_cmp++; if (unit_r !== 3'd3 || unit_c !== 3'd3 || unit_data !== pat(1)) begin
               n_bad++; $display("FAIL basic_unit_ops k=%0d: got r=%0d c=%0d data=%h", k, unit_r, unit_c, unit_data);
            end
         end
      end
      exp_res_r = 3'd3; exp_res_c = 3'd3; exp_res_data = pat(2);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err); end
      n_cmp++; if (res_r !== exp_res_r || res_c !== exp_res_c || res_data !== exp_res_data) begin
         n_bad++; $display("FAIL basic_res: got r=%0d c=%0d data=%h want r=%0d c=%0d data=%h",
                           res_r, res_c, res_data, exp_res_r, exp_res_c, exp_res_data);
      end
      tick;
      n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL basic_done_hold: got %b want 01", done); end
      req = 2'b00;
      tick;
      n_cmp++; if (done !== 2'b00 || gnt !== 2'b00) begin
         n_bad++; $display("FAIL basic_release: got done=%b gnt=%b want 00/00", done, gnt);
      end
   endtask

   task automatic test_rr;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      exp_res_r = '0; exp_res_c = '0; exp_res_data = '0;
      req_r = {3'd4, 3'd2}; req_c = {3'd4, 3'd2}; req_data = {pat(4), pat(3)};
      unit_r_out = 3'd2; unit_c_out = 3'd2; unit_data_out = pat(5);
      req = 2'b11;
      for (int k = 1; k <= 6; k++) begin
         tick;
         n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL rr_first_gnt k=%0d: got %b want 01", k, gnt); end
      end
      n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL rr_first_done: got %b want 01", done); end
      exp_res_r = 3'd2; exp_res_c = 3'd2; exp_res_data = pat(5);
      n_cmp++; if (res_r !== exp_res_r || res_data !== exp_res_data) begin
         n_bad++; $display("FAIL rr_first_res: got r=%0d data=%h want r=%0d data=%h", res_r, res_data, exp_res_r, exp_res_data);
      end
      unit_r_out = 3'd4; unit_c_out = 3'd4; unit_data_out = pat(6);
      req = 2'b10;
      tick;
      n_cmp++; if (gnt !== 2'b00 || done !== 2'b00) begin
         n_bad++; $display("FAIL rr_idle_gap: got gnt=%b done=%b want 00/00", gnt, done);
      end
      for (int k = 1; k <= 6; k++) begin
         tick;
         n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL rr_second_gnt k=%0d: got %b want 10", k, gnt); end
         if (k == 2) begin
            n_cmp++; if (unit_r !== 3'd4 || unit_data !== pat(4)) begin
               n_bad++; $display("FAIL rr_second_ops: got r=%0d data=%h want r=4 data=%h", unit_r, unit_data, pat(4));
            end
         end
      end
      exp_res_r = 3'd4; exp_res_c = 3'd4; exp_res_data = pat(6);
      n_cmp++; if (done !== 2'b10 || err !== 1'b0) begin
         n_bad++; $display("FAIL rr_second_done: got done=%b err=%b want 10/0", done, err);
      end
      n_cmp++; if (res_r !== exp_res_r || res_c !== exp_res_c || res_data !== exp_res_data) begin
         n_bad++; $display("FAIL rr_second_res: got r=%0d c=%0d data=%h want r=%0d c=%0d data=%h",
                           res_r, res_c, res_data, exp_res_r, exp_res_c, exp_res_data);
      end
      req = 2'b00;
      tick;
   endtask

   task automatic test_reject;
      req_r = {3'd6, 3'd3}; req_c = {3'd2, 3'd3}; req_data = {pat(13), pat(14)};
      unit_r_out = 3'd1; unit_c_out = 3'd1; unit_data_out = pat(7);
      req = 2'b10;
      for (int k = 1; k <= 4; k++) begin
         tick;
         n_cmp++; if (unit_en !== 1'b0) begin n_bad++; $display("FAIL reject_unit_en k=%0d: got %b want 0", k, unit_en); end
         n_cmp++; if (done !== ((k >= 2) ? 2'b10 : 2'b00) || err !== (k >= 2)) begin
            n_bad++; $display("FAIL reject_done k=%0d: got done=%b err=%b want %b/%b",
                              k, done, err, ((k >= 2) ? 2'b10 : 2'b00), (k >= 2));
         end
      end
      n_cmp++; if (res_r !== exp_res_r || res_c !== exp_res_c || res_data !== exp_res_data) begin
         n_bad++; $display("FAIL reject_res: got r=%0d c=%0d data=%h want r=%0d c=%0d data=%h",
                           res_r, res_c, res_data, exp_res_r, exp_res_c, exp_res_data);
      end
      req = 2'b00;
      tick;
      n_cmp++; if (done !== 2'b00 || err !== 1'b0) begin
         n_bad++; $display("FAIL reject_release: got done=%b err=%b want 00/0", done, err);
      end
   endtask

`ifdef MATOP_TIMEOUT_EN
   task automatic test_timeout;
      req_r = {3'd1, 3'd3}; req_c = {3'd1, 3'd3}; req_data = {pat(9), pat(1)};
      unit_r_out = 3'd5; unit_c_out = 3'd1; unit_data_out = pat(8);
      req = 2'b01;
      for (int k = 1; k <= 12; k++) begin
         tick;
         n_cmp++; if (unit_en !== (k >= 2 && k <= 11) || done !== ((k == 12) ? 2'b01 : 2'b00)) begin
            n_bad++; $display("FAIL timeout_seq k=%0d: got en=%b done=%b want %b/%b",
                              k, unit_en, done, (k >= 2 && k <= 11), ((k == 12) ? 2'b01 : 2'b00));
         end
         if (k == 4) unit_busy = 1'b1;
      end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", err); end
      n_cmp++; if (res_r !== exp_res_r || res_data !== exp_res_data) begin
         n_bad++; $display("FAIL timeout_res: got r=%0d data=%h want r=%0d data=%h", res_r, res_data, exp_res_r, exp_res_data);
      end
      unit_busy = 1'b0;
      req = 2'b00;
      tick;
   endtask
`else
   task automatic test_busy;
      req_r = {3'd1, 3'd3}; req_c = {3'd1, 3'd3}; req_data = {pat(9), pat(1)};
      unit_r_out = 3'd5; unit_c_out = 3'd1; unit_data_out = pat(8);
      req = 2'b01;
      for (int k = 1; k <= 16; k++) begin
         tick;
         n_cmp++; if (unit_en !== (k >= 2 && k <= 15) || done !== ((k == 16) ? 2'b01 : 2'b00)) begin
            n_bad++; $display("FAIL busy_seq k=%0d: got en=%b done=%b want %b/%b",
                              k, unit_en, done, (k >= 2 && k <= 15), ((k == 16) ? 2'b01 : 2'b00));
         end
         if (k == 4) unit_busy = 1'b1;
         if (k == 14) unit_busy = 1'b0;
      end
      exp_res_r = 3'd5; exp_res_c = 3'd1; exp_res_data = pat(8);
      n_cmp++; if (err !== 1'b0 || res_r !== exp_res_r || res_c !== exp_res_c || res_data !== exp_res_data) begin
         n_bad++; $display("FAIL busy_res: got err=%b r=%0d c=%0d data=%h want 0 r=%0d c=%0d data=%h",
                           err, res_r, res_c, res_data, exp_res_r, exp_res_c, exp_res_data);
      end
      req = 2'b00;
      tick;
   endtask
`endif

   task automatic test_abort;
      req_r = {3'd2, 3'd3}; req_c = {3'd2, 3'd3}; req_data = {pat(10), pat(1)};
      unit_r_out = 3'd2; unit_c_out = 3'd2; unit_data_out = pat(11);
      req = 2'b01;
      tick; tick; tick;
      n_cmp++; if (unit_en !== 1'b1) begin n_bad++; $display("FAIL abort_pre_en: got %b want 1", unit_en); end
      req = 2'b00;
      tick;
      n_cmp++; if (unit_en !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) begin
         n_bad++; $display("FAIL abort_stop: got en=%b gnt=%b done=%b want 0/00/00", unit_en, gnt, done);
      end
      tick; tick;
      n_cmp++; if (done !== 2'b00 || res_r !== exp_res_r || res_data !== exp_res_data) begin
         n_bad++; $display("FAIL abort_res: got done=%b r=%0d data=%h want 00 r=%0d data=%h",
                           done, res_r, res_data, exp_res_r, exp_res_data);
      end
      req = 2'b11;
      tick;
      n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL abort_last_served: got gnt=%b want 10", gnt); end
      req = 2'b00;
      tick;
      n_cmp++; if (gnt !== 2'b00 || done !== 2'b00) begin
         n_bad++; $display("FAIL abort_check: got gnt=%b done=%b want 00/00", gnt, done);
      end
   endtask

   task automatic test_reset_capture;
      req_r = {3'd1, 3'd4}; req_c = {3'd1, 3'd4}; req_data = {pat(9), pat(15)};
      unit_r_out = 3'd4; unit_c_out = 3'd4; unit_data_out = pat(12);
      req = 2'b01;
      for (int k = 1; k <= 5; k++) tick;
      n_cmp++; if (unit_en !== 1'b1 || done !== 2'b00) begin
         n_bad++; $display("FAIL rstcap_pre: got en=%b done=%b want 1/00", unit_en, done);
      end
      reset = 1'b1;
      tick;
      n_cmp++; if (gnt !== 2'b00 || done !== 2'b00 || err !== 1'b0 || unit_en !== 1'b0) begin
         n_bad++; $display("FAIL rstcap_ctrl: got gnt=%b done=%b err=%b en=%b want zeros", gnt, done, err, unit_en);
      end
      n_cmp++; if (unit_r !== 3'd0 || unit_c !== 3'd0 || unit_data !== '0) begin
         n_bad++; $display("FAIL rstcap_unit: got r=%0d c=%0d data=%h want zeros", unit_r, unit_c, unit_data);
      end
      n_cmp++; if (res_r !== 3'd0 || res_c !== 3'd0 || res_data !== '0) begin
         n_bad++; $display("FAIL rstcap_res: got r=%0d c=%0d data=%h want zeros", res_r, res_c, res_data);
      end
      reset = 1'b0;
      req = 2'b00;
      tick;
      n_cmp++; if (done !== 2'b00 || gnt !== 2'b00) begin
         n_bad++; $display("FAIL rstcap_after: got done=%b gnt=%b want 00/00", done, gnt);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_rr;
      test_reject;
`ifdef MATOP_TIMEOUT_EN
      test_timeout;
`else
      test_busy;
`endif
      test_abort;
      test_reset_capture;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/matrix_op_arbiter.md
MATRIX_OP_ARBITER -- requirements
Module: matrix_op_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 9: element width in bits.
REQ-002 Parameter SETTLE_CYCLES, default 2: minimum number of cycles unit_en is held before result capture; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: busy watchdog limit in cycles; legal range 1..255.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  2  level request per requester i; held until done[i] is seen.
REQ-007 req_r, req_c  in  2x3 each  operand row and column counts, requester i in bits [3i+2:3i].
REQ-008 req_data  in  2x25xDATA_WIDTH  row-major operand matrix, flattened per requester.
REQ-009 gnt  out  2  one-hot grant, zero when idle.
REQ-010 done  out  2  completion to the granted requester.
REQ-011 err  out  1  valid while any done bit is high; 1 = rejected or timed out.
REQ-012 res_r, res_c  out  3 each; res_data  out  25xDATA_WIDTH  registered result.
REQ-013 unit_en  out  1; unit_r, unit_c  out  3 each; unit_data  out  25xDATA_WIDTH  drive to the shared matrix op unit.
REQ-014 unit_busy  in  1; unit_r_out, unit_c_out  in  3 each; unit_data_out  in  25xDATA_WIDTH  unit result.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, LAUNCH, SETTLE, CAPTURE and DONE.
REQ-016 In IDLE with any req bit high, the block SHALL pick a winner round-robin (the requester not last served wins a tie), latch its r/c/data, enter CHECK and raise gnt for that requester the same cycle.
REQ-017 CHECK SHALL go to DONE with err=1 if r or c is outside 1..5, without ever asserting unit_en; otherwise it SHALL go to LAUNCH.
REQ-018 unit_en SHALL be high from LAUNCH through CAPTURE inclusive; unit_r/unit_c/unit_data SHALL stay constant over that span.
REQ-019 SETTLE SHALL last at least SETTLE_CYCLES cycles and SHALL exit to CAPTURE on the first cycle after that with unit_busy=0.
REQ-020 CAPTURE SHALL register unit_r_out, unit_c_out and unit_data_out into res_r, res_c and res_data.
REQ-021 Latency: with unit_busy low, done SHALL assert exactly SETTLE_CYCLES+4 cycles after the cycle in which IDLE samples req.
REQ-022 In DONE, done[winner]=1 and err SHALL hold until req[winner] is 0; the FSM SHALL then return to IDLE, clear gnt and record the winner as last served.
REQ-023 A req[winner] drop before DONE SHALL abort: unit_en low next cycle, return to IDLE, no done pulse, res_* unchanged, last-served updated.
REQ-024 res_* SHALL keep their value until the next CAPTURE; a rejected or timed-out operation SHALL NOT modify them.
REQ-025 A request from the loser SHALL wait, unserviced, and SHALL be served on the next IDLE.

Reset
REQ-026 Reset SHALL force IDLE, gnt=0, done=0, err=0, unit_en=0, unit_* operands=0, res_*=0, counters=0 and last-served=1, so requester 0 wins the first tie.
REQ-027 Reset mid-operation SHALL take effect on the next edge, with no done pulse.

Configuration
REQ-028 With MATOP_TIMEOUT_EN defined, if unit_busy stays high for TIMEOUT_CYCLES cycles after the settle minimum, SETTLE SHALL go to DONE with err=1.
REQ-029 Without MATOP_TIMEOUT_EN, SETTLE SHALL wait on unit_busy indefinitely and no watchdog counter is built.

Structure
REQ-030 Package matop_pkg SHALL hold the FSM state enum, MAT_DIM=5, MAT_ELEMS=25 and a dimension-valid function.
REQ-031 Winner selection SHALL be a sub-module rr_arbiter2 (2-way round-robin, combinational pick, last-served input).

Verification
REQ-032 req=01, r=c=3, unit_busy=0, SETTLE_CYCLES=2 -> gnt=01 at cycle 1, unit_en cycles 2-5, done[0] at cycle 6, err=0, res_data equals unit_data_out.
REQ-033 req=11 from reset -> requester 0 is served first; after req[0] drops, requester 1 is granted with no new request edge.
REQ-034 req=10, r=6, c=2 -> done[1] with err=1, unit_en never high, res_* unchanged.
REQ-035 unit_busy held high for 10 cycles -> done delayed by exactly 10 cycles versus REQ-032; with MATOP_TIMEOUT_EN and TIMEOUT_CYCLES=8, busy stuck high -> err=1 after 8 busy cycles.
REQ-036 req[0] dropped during SETTLE -> unit_en low next cycle, IDLE, no done; a reset asserted in CAPTURE -> all outputs at their reset values next cycle.
